parity_stream_unit: RTL and testbench

//  Streaming parity generator/checker: per-word parity plus frame-level column parity.

---
 rtl/parity_pkg.sv | 25 ++
 rtl/parity_word.sv | 19 +
 rtl/parity_stream_unit.sv | 149 ++++++++++++++
 tb/tb_parity_stream_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Package     : parity_pkg
// Description : Shared state encoding, mode constants and beat-flag type for
//               the streaming parity unit.
// Revision    : 1.0  initial release
// ============================================================================
package parity_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    typedef struct packed {
        logic last;
        logic tag;
        logic err;
        logic ovf;
    } beat_flags_t;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_word.sv
`default_nettype none
// ============================================================================
// Module      : parity_word
// Description : Combinational word parity: reduction XOR of data, inverted
//               when odd parity is selected.
// Revision    : 1.0  initial release
// ============================================================================
module parity_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             par
);

    assign par = (^data) ^ odd;

endmodule : parity_word
`default_nettype wire

// File: rtl/parity_stream_unit.sv
`default_nettype none
// ============================================================================
// Module      : parity_stream_unit
// Description : Streaming per-word and frame column parity generator/checker
//               with a single registered output stage.
// Revision    : 1.0  initial release
// ============================================================================
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_FRAME = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_mode,
    input  logic             odd_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_last,
    output logic             out_tag,
    output logic             out_err,
    output logic             out_ovf
);

    localparam int c_CNT_W = $clog2(MAX_FRAME + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FORCE = c_CNT_W'(MAX_FRAME - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mode;
    logic               r_odd;
    logic               r_ovf_pend;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_par;
    beat_flags_t        r_out_flags;

    logic               w_out_free;
    logic               w_accept;
    logic               w_first;
    logic               w_mode;
    logic               w_odd;
    logic               w_forced;
    logic               w_end;
    logic [WIDTH-1:0]   w_acc_in;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_chk_err;
    logic               w_tail_load;
    logic [WIDTH-1:0]   w_load_data;
    logic               w_load_odd;
    logic               w_load_par;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = !rst && (r_state != S_TAIL) && w_out_free;
    assign w_accept   = in_valid && in_ready;

    // Mode and polarity come straight from the inputs on a frame's first word.
    assign w_first    = (r_state == S_IDLE);
    assign w_mode     = w_first ? chk_mode : r_mode;
    assign w_odd      = w_first ? odd_sel  : r_odd;

    assign w_forced   = !w_first && !in_last && (r_cnt == c_CNT_FORCE);
    assign w_end      = in_last || w_forced;
    assign w_acc_in   = w_first ? '0 : r_acc;
    assign w_acc_next = w_acc_in ^ in_data;
    assign w_chk_err  = (in_data != (w_acc_in ^ {WIDTH{w_odd}}));

    assign w_tail_load = (r_state == S_TAIL) && w_out_free;
    assign w_load_data = w_tail_load ? (r_acc ^ {WIDTH{r_odd}}) : in_data;
    assign w_load_odd  = w_tail_load ? r_odd : w_odd;

    parity_word #(
        .WIDTH (WIDTH)
    ) u_parity_word (
        .data (w_load_data),
        .odd  (w_load_odd),
        .par  (w_load_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mode      <= MODE_GEN;
            r_odd       <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_par   <= 1'b0;
            r_out_flags <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_par   <= w_load_par;
            if (w_first) begin
                r_mode <= chk_mode;
                r_odd  <= odd_sel;
            end
            if (!w_end) begin
                r_state     <= S_FRAME;
                r_acc       <= w_acc_next;
                r_cnt       <= r_cnt + c_CNT_W'(1);
                r_out_flags <= '0;
            end else if (w_mode == MODE_GEN) begin
                // Tail beat carries last/ovf; the data beat itself is not last.
                r_state     <= S_TAIL;
                r_acc       <= w_acc_next;
                r_ovf_pend  <= w_forced;
                r_out_flags <= '0;
            end else begin
                r_state     <= S_IDLE;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_flags <= '{last: 1'b1, tag: 1'b0, err: w_chk_err, ovf: w_forced};
            end
        end else if (w_tail_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_par   <= w_load_par;
            r_out_flags <= '{last: 1'b1, tag: 1'b1, err: 1'b0, ovf: r_ovf_pend};
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_pend  <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_par   = r_out_par;
    assign out_last  = r_out_flags.last;
    assign out_tag   = r_out_flags.tag;
    assign out_err   = r_out_flags.err;
    assign out_ovf   = r_out_flags.ovf;

endmodule : parity_stream_unit
`default_nettype wire

// File: tb/tb_parity_stream_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_stream_unit
// Description : Scoreboard bench for parity_stream_unit (WIDTH=8, MAX_FRAME=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_parity_stream_unit;

    localparam int c_W   = 8;
    localparam int c_MAX = 4;

    logic           clk;
    logic           rst;
    logic           chk_mode;
    logic           odd_sel;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_data;
    logic           out_par;
    logic           out_last;
    logic           out_tag;
    logic           out_err;
    logic           out_ovf;

    parity_stream_unit #(
        .WIDTH     (c_W),
        .MAX_FRAME (c_MAX)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .chk_mode  (chk_mode),
        .odd_sel   (odd_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_par   (out_par),
        .out_last  (out_last),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Beat packing: {data, par, last, tag, err, ovf}
    logic [12:0] sb_q[$];
    logic        m_in_frame;
    logic        m_mode;
    logic        m_odd;
    logic [7:0]  m_acc;
    int          m_cnt;

    function automatic logic [12:0] mk(input logic [7:0] d, input logic odd,
                                       input logic l, input logic t, input logic e, input logic o);
        return {d, (^d) ^ odd, l, t, e, o};
    endfunction

    task automatic model_accept();
        logic       forced;
        logic       fin;
        logic [7:0] mask;
        if (!m_in_frame) begin
            m_mode = chk_mode;
            m_odd  = odd_sel;
            m_acc  = 8'h00;
            m_cnt  = 0;
        end
        m_cnt++;
        mask   = {8{m_odd}};
        forced = !in_last && (m_cnt == c_MAX);
        fin    = in_last || forced;
        if (!m_mode) begin
            m_acc = m_acc ^ in_data;
            sb_q.push_back(mk(in_data, m_odd, 1'b0, 1'b0, 1'b0, 1'b0));
            if (fin) sb_q.push_back(mk(m_acc ^ mask, m_odd, 1'b1, 1'b1, 1'b0, forced));
        end else if (fin) begin
            sb_q.push_back(mk(in_data, m_odd, 1'b1, 1'b0, in_data != (m_acc ^ mask), forced));
        end else begin
            m_acc = m_acc ^ in_data;
            sb_q.push_back(mk(in_data, m_odd, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        m_in_frame = !fin;
    endtask

    // Sampler runs 1 time unit before each rising edge.
    logic [12:0] cur;
    logic [12:0] hold_beat;
    logic        hold_v;
    initial begin
        m_in_frame = 1'b0;
        m_acc      = 8'h00;
        m_cnt      = 0;
        m_mode     = 1'b0;
        m_odd      = 1'b0;
        hold_v     = 1'b0;
        hold_beat  = '0;
        forever begin
            @(negedge clk);
            #4;
            cur = {out_data, out_par, out_last, out_tag, out_err, out_ovf};
            if (rst) begin
                sb_q.delete();
                m_in_frame = 1'b0;
                m_acc      = 8'h00;
                m_cnt      = 0;
                hold_v     = 1'b0;
            end else begin
                if (hold_v && out_valid) check_eq("hold", cur, hold_beat);
                hold_v    = out_valid && !out_ready;
                hold_beat = cur;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) check_eq("unexpected_beat", sb_q.size(), 1);
                    else                  check_eq("beat", cur, sb_q.pop_front());
                end
                if (in_valid && in_ready) model_accept();
            end
        end
    end

    logic rnd_bp;
    initial begin
        rnd_bp = 1'b0;
        forever begin
            @(negedge clk);
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] d, input logic l, input logic cm, input logic od);
        int n = 0;
        in_data  = d;
        in_last  = l;
        chk_mode = cm;
        odd_sel  = od;
        in_valid = 1'b1;
        forever begin
            #4;
            if (in_ready) break;
            @(negedge clk);
            n++;
            if (n > 50) begin
                check_eq("send_timeout", n, 0);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        chk_mode  = 1'b0;
        odd_sel   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_beat", {out_data, out_par, out_last, out_tag, out_err, out_ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Generate, even: 01, 03 -> tail 02
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("tail_in_ready", in_ready, 0);
        @(negedge clk);
        drain();

        // Generate, odd, single word FF -> tail 00
        send(8'hFF, 1'b1, 1'b0, 1'b1);
        drain();

        // Check, even: good and bad frames
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        send(8'hFE, 1'b1, 1'b1, 1'b0);
        drain();

        // Overflow: 4 words without last, then a fresh frame
        send(8'h11, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0, 1'b0);
        send(8'h88, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0, 1'b0);
        drain();

        // Mode change mid-frame must be ignored (check frame, odd)
        send(8'h0F, 1'b0, 1'b1, 1'b1);
        send(8'hF0, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(8'hA1, 1'b0, 1'b0, 1'b0);
        in_data  = 8'hB2;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            #1;
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_data", out_data, 8'hA1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(8'hB2, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset mid-frame
        send(8'h10, 1'b0, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(8'h0F, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 1'b1, 1'b0, 1'b0);
        drain();

        // Randomised frames with random output backpressure
        rnd_bp = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int len;
            logic cm;
            logic od;
            len = $urandom_range(1, 5);
            cm  = 1'($urandom_range(0, 1));
            od  = 1'($urandom_range(0, 1));
            for (int w = 0; w < len; w++) begin
                send(8'($urandom_range(0, 255)), (w == len - 1), cm, od);
            end
        end
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", n_checks);
        $fatal(1, "timeout");
    end

endmodule : tb_parity_stream_unit
`default_nettype wire
